// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported unified memory between the fetch stage and the
// memory stage of the Y86-64 pipeline. The memory stage (older instruction)
// normally wins, but fetch is guaranteed a grant after MAX_WAIT consecutive
// losses. Fetches are two memory beats that assemble 10 instruction bytes.
// An access that sees mem_ready low for TIMEOUT cycles is aborted with an
// error pulse.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   if_req/if_addr         fetch request (held until if_ack)
//   if_ack/if_data/if_err  fetch completion pulse, 80-bit instruction bytes, timeout
//   dm_req/dm_we/dm_addr/dm_wdata  data request (held until dm_ack)
//   dm_ack/dm_rdata/dm_err data completion pulse, read data, timeout
//   mem_req/mem_we/mem_addr/mem_wdata  registered memory command
//   mem_rdata/mem_ready    memory response
//   busy                   an access is in progress
module mem_port_arbiter #(
    parameter int MAX_WAIT = 3,
    parameter int TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_ack,
    output logic [79:0] if_data,
    output logic        if_err,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [63:0] dm_addr,
    input  logic [63:0] dm_wdata,
    output logic        dm_ack,
    output logic [63:0] dm_rdata,
    output logic        dm_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ready,
    output logic        busy
);

    localparam int SW = $clog2(MAX_WAIT + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_WAIT);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] D_ACC   = 2'd1;
    localparam logic [1:0] I_BEAT0 = 2'd2;
    localparam logic [1:0] I_BEAT1 = 2'd3;

    logic [1:0]    state;
    logic [SW-1:0] starve_cnt;
    logic [WW-1:0] wait_cnt;
    logic [63:0]   beat0;

    logic turnaround;
    logic dm_go;
    logic if_go;
    logic fetch_first;
    logic grant_d;
    logic grant_i;
    logic timed_out;

    // An IDLE cycle that carries an ack is a turnaround cycle: the acked
    // requester's req may still be high, and no grant is made so that the
    // data stage can re-request and keep its priority over fetch until the
    // starvation counter forces a fetch grant.
    always_comb begin
        turnaround  = if_ack | dm_ack;
        dm_go       = dm_req & ~turnaround;
        if_go       = if_req & ~turnaround;
        fetch_first = if_go && (starve_cnt >= STARVE_MAX);
        grant_d     = dm_go && !fetch_first;
        grant_i     = if_go && !grant_d;
        timed_out   = !mem_ready && (wait_cnt == WAIT_LAST);
    end

    assign busy = (state != IDLE);

    // Main sequencer. Ack, error and data outputs default to zero every cycle
    // so each completion produces a single-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            wait_cnt   <= '0;
            beat0      <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_ack     <= 1'b0;
            if_err     <= 1'b0;
            if_data    <= '0;
            dm_ack     <= 1'b0;
            dm_err     <= 1'b0;
            dm_rdata   <= '0;
        end else begin
            if_ack   <= 1'b0;
            if_err   <= 1'b0;
            if_data  <= '0;
            dm_ack   <= 1'b0;
            dm_err   <= 1'b0;
            dm_rdata <= '0;

            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (grant_i || !if_req) begin
                        starve_cnt <= '0;
                    end else if (grant_d && (starve_cnt < STARVE_MAX)) begin
                        starve_cnt <= starve_cnt + 1'b1;
                    end
                    if (grant_d) begin
                        state     <= D_ACC;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                    end else if (grant_i) begin
                        state    <= I_BEAT0;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= if_addr;
                    end
                end

                D_ACC: begin
                    if (mem_ready || timed_out) begin
                        dm_ack   <= 1'b1;
                        dm_err   <= !mem_ready;
                        dm_rdata <= (mem_ready && !mem_we) ? mem_rdata : 64'd0;
                        state    <= IDLE;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                I_BEAT0: begin
                    if (mem_ready) begin
                        // Second beat address wraps modulo 2^64.
                        beat0    <= mem_rdata;
                        mem_addr <= mem_addr + 64'd8;
                        state    <= I_BEAT1;
                        wait_cnt <= '0;
                    end else if (timed_out) begin
                        if_ack   <= 1'b1;
                        if_err   <= 1'b1;
                        state    <= IDLE;
                        mem_req  <= 1'b0;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                I_BEAT1: begin
                    if (mem_ready || timed_out) begin
                        if_ack   <= 1'b1;
                        if_err   <= !mem_ready;
                        if_data  <= mem_ready ? {mem_rdata[15:0], beat0} : 80'd0;
                        beat0    <= '0;
                        state    <= IDLE;
                        mem_req  <= 1'b0;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed self-checking bench for mem_port_arbiter: reset, zero-wait data
// read/write, wrapping two-beat fetch, data/fetch contention with the
// starvation limit, data timeout, and reset in the middle of a fetch.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_ack;
    logic [79:0] if_data;
    logic        if_err;
    logic        dm_req;
    logic        dm_we;
    logic [63:0] dm_addr;
    logic [63:0] dm_wdata;
    logic        dm_ack;
    logic [63:0] dm_rdata;
    logic        dm_err;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ready;
    logic        busy;

    int n_compared;
    int n_mismatched;

    mem_port_arbiter #(.MAX_WAIT(3), .TIMEOUT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_data   (if_data),
        .if_err    (if_err),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_ack    (dm_ack),
        .dm_rdata  (dm_rdata),
        .dm_err    (dm_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .busy      (busy)
    );

    // 10 ns clock, first rising edge at 5 ns.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives all request-side inputs at once.
    task automatic applyStimulus(input logic d_req, input logic d_we, input logic [63:0] d_addr,
                                 input logic [63:0] d_wdata, input logic i_req, input logic [63:0] i_addr);
        dm_req   = d_req;
        dm_we    = d_we;
        dm_addr  = d_addr;
        dm_wdata = d_wdata;
        if_req   = i_req;
        if_addr  = i_addr;
    endtask

    // Advance one clock and settle 1 ns past the edge for driving and sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int data_grants;
        int fetch_seen;
        int overlap;
        int waited;
        logic prev_req;

        n_compared   = 0;
        n_mismatched = 0;
        rst       = 1'b0;
        mem_rdata = '0;
        mem_ready = 1'b0;
        applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 64'd0);

        // Asynchronous reset mid-cycle clears outputs without a clock edge.
        #3 rst = 1'b1;
        #1;
        checkOutput("reset_ctrl", {73'd0, if_ack, if_err, dm_ack, dm_err, mem_req, mem_we, busy}, 80'd0);
        checkOutput("reset_addr", mem_addr, 80'd0);
        checkOutput("reset_ifdata", if_data, 80'd0);
        #10 rst = 1'b0;
        step();
        step();
        checkOutput("idle_no_req", {78'd0, mem_req, busy}, 80'd0);

        // Zero-wait data read.
        mem_ready = 1'b1;
        mem_rdata = 64'h1122334455667788;
        applyStimulus(1'b1, 1'b0, 64'h40, 64'd0, 1'b0, 64'd0);
        step();
        checkOutput("rd_cmd", {77'd0, mem_req, mem_we, busy}, {77'd0, 3'b101});
        checkOutput("rd_addr", mem_addr, 80'h40);
        checkOutput("rd_ack_early", dm_ack, 80'd0);
        step();
        checkOutput("rd_ack", {78'd0, dm_ack, dm_err}, {78'd0, 2'b10});
        checkOutput("rd_data", dm_rdata, 80'h1122334455667788);
        applyStimulus(1'b0, 1'b0, 64'h40, 64'd0, 1'b0, 64'd0);
        step();
        checkOutput("rd_clear", {15'd0, dm_ack, dm_rdata}, 80'd0);
        checkOutput("rd_idle", busy, 80'd0);

        // Zero-wait data write: read data must read back as zero.
        applyStimulus(1'b1, 1'b1, 64'h80, 64'hAB, 1'b0, 64'd0);
        step();
        checkOutput("wr_cmd", {78'd0, mem_req, mem_we}, {78'd0, 2'b11});
        checkOutput("wr_wdata", mem_wdata, 80'hAB);
        step();
        checkOutput("wr_ack", dm_ack, 80'd1);
        checkOutput("wr_rdata_zero", dm_rdata, 80'd0);
        applyStimulus(1'b0, 1'b0, 64'h80, 64'hAB, 1'b0, 64'd0);
        step();
        checkOutput("wr_idle_hold", {mem_addr, 14'd0, mem_req, mem_we}, {64'h80, 16'd0});

        // Fetch whose second beat wraps to address 0.
        mem_rdata = 64'h0706050403020100;
        applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 1'b1, 64'hFFFFFFFFFFFFFFF8);
        step();
        checkOutput("if_beat0_addr", mem_addr, 80'hFFFFFFFFFFFFFFF8);
        checkOutput("if_beat0_cmd", {78'd0, mem_req, mem_we}, {78'd0, 2'b10});
        step();
        checkOutput("if_beat1_addr", mem_addr, 80'd0);
        checkOutput("if_ack_early", if_ack, 80'd0);
        mem_rdata = 64'h0F0E0D0C0B0A0908;
        step();
        checkOutput("if_ack", {78'd0, if_ack, if_err}, {78'd0, 2'b10});
        checkOutput("if_data", if_data, 80'h09080706050403020100);
        applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 64'hFFFFFFFFFFFFFFF8);
        step();
        checkOutput("if_clear", {if_data[78:0], if_ack}, 80'd0);

        // Contention: both held; data should win three times, then fetch.
        mem_rdata   = 64'h5555AAAA5555AAAA;
        applyStimulus(1'b1, 1'b0, 64'h200, 64'd0, 1'b1, 64'h100);
        data_grants = 0;
        fetch_seen  = 0;
        overlap     = 0;
        prev_req    = 1'b0;
        for (int i = 0; i < 40 && fetch_seen == 0; i++) begin
            step();
            if (if_ack && dm_ack) overlap++;
            if (mem_req && !prev_req) begin
                if (mem_addr == 64'h200) data_grants++;
                else fetch_seen = 1;
            end
            prev_req = mem_req;
        end
        checkOutput("cont_fetch_granted", fetch_seen, 80'd1);
        checkOutput("cont_data_grants", data_grants, 80'd3);
        checkOutput("cont_fetch_addr", mem_addr, 80'h100);
        checkOutput("cont_starve_clear", dut.starve_cnt, 80'd0);
        waited = 0;
        for (int i = 0; i < 10 && waited == 0; i++) begin
            step();
            if (if_ack && dm_ack) overlap++;
            if (if_ack) waited = 1;
        end
        checkOutput("cont_if_ack", waited, 80'd1);
        applyStimulus(1'b1, 1'b0, 64'h200, 64'd0, 1'b0, 64'h100);
        waited = 0;
        for (int i = 0; i < 10 && waited == 0; i++) begin
            step();
            if (if_ack && dm_ack) overlap++;
            if (dm_ack) waited = 1;
        end
        checkOutput("cont_dm_ack", waited, 80'd1);
        checkOutput("cont_ack_overlap", overlap, 80'd0);
        applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 64'd0);
        step();
        step();

        // Data timeout: memory never ready.
        mem_ready = 1'b0;
        mem_rdata = 64'hDEAD;
        applyStimulus(1'b1, 1'b0, 64'h300, 64'd0, 1'b0, 64'd0);
        step();
        checkOutput("to_busy", busy, 80'd1);
        waited = 0;
        for (int i = 1; i <= 40 && waited == 0; i++) begin
            step();
            if (dm_ack) waited = i;
        end
        checkOutput("to_cycles", waited, 80'd15);
        checkOutput("to_ack_err", {78'd0, dm_ack, dm_err}, {78'd0, 2'b11});
        checkOutput("to_rdata", dm_rdata, 80'd0);
        checkOutput("to_idle", busy, 80'd0);
        applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 64'd0);
        step();
        checkOutput("to_clear", {78'd0, dm_ack, dm_err}, 80'd0);

        // Reset during I_BEAT1, then the held request restarts from beat 0.
        mem_ready = 1'b1;
        mem_rdata = 64'h1234;
        applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 1'b1, 64'h500);
        step();
        step();
        checkOutput("rst_beat1_addr", mem_addr, 80'h508);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_mid_fetch", {77'd0, if_ack, mem_req, busy}, 80'd0);
        #2 rst = 1'b0;
        step();
        checkOutput("rst_restart_addr", mem_addr, 80'h500);
        checkOutput("rst_restart_cmd", {78'd0, mem_req, if_ack}, {78'd0, 2'b10});
        step();
        step();
        checkOutput("rst_restart_ack", if_ack, 80'd1);
        checkOutput("rst_restart_data", if_data, {16'h1234, 64'h1234});
        applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 64'd0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the fetch stage and the memory stage of the Y86-64 pipeline.
- Sequences multi-cycle memory accesses, including a two-beat instruction fetch that assembles 10 instruction bytes.
- Gives priority to the memory stage (the older instruction), bounded by an anti-starvation counter for fetch.
- Returns single-cycle acks that the hazard logic uses to hold F_stall/W_stall until the requesting stage is served.

Parameters:
- MAX_WAIT, 3, consecutive fetch losses after which fetch wins the next arbitration.
- TIMEOUT, 15, cycles of mem_ready low in an access state before the access is aborted with an error.

Ports:
- clk in 1: clock; all state updates on the rising edge.
- rst in 1: asynchronous, active-high reset.
- if_req in 1: fetch request; held, with if_addr stable, until if_ack.
- if_addr in 64: byte address of the instruction.
- if_ack out 1: one-cycle pulse; if_data and if_err are valid in that cycle.
- if_data out 80: instruction bytes, equal to {beat1[15:0], beat0[63:0]}, little-endian.
- if_err out 1: fetch timed out (stage maps this to ADR status).
- dm_req in 1: data request; held, with dm_we, dm_addr and dm_wdata stable, until dm_ack.
- dm_we in 1: 1 = write, 0 = read.
- dm_addr in 64: data address.
- dm_wdata in 64: write data.
- dm_ack out 1: one-cycle pulse.
- dm_rdata out 64: read data, valid with dm_ack; 0 on a write ack or on an error.
- dm_err out 1: data access timed out.
- mem_req out 1: memory access active.
- mem_we out 1: write strobe.
- mem_addr out 64: memory address.
- mem_wdata out 64: memory write data.
- mem_rdata in 64: read data, valid when mem_ready = 1.
- mem_ready in 1: access complete this cycle.
- busy out 1: state is not IDLE.

Behaviour:
- Reset: state = IDLE; all outputs, starve_cnt and wait_cnt = 0. Reset asserted mid-access aborts the access with no ack; the requester re-requests.
- States and arbitration:
  - IDLE: a requester whose ack is high this cycle is masked, because its req may still be high. Among unmasked requests:
  - Go to D_ACC if dm_req and NOT(if_req and starve_cnt >= MAX_WAIT).
  - Otherwise go to I_BEAT0 if if_req.
  - Otherwise stay in IDLE.
  - Request fields are latched on the grant edge.
- Memory outputs:
  - D_ACC: mem_req = 1, mem_we = dm_we, mem_addr = dm_addr, mem_wdata = dm_wdata.
  - I_BEAT0: mem_req = 1, mem_we = 0, mem_addr = if_addr.
  - I_BEAT1: mem_req = 1, mem_we = 0, mem_addr = if_addr + 8, modulo 2^64 (wrap).
  - IDLE: mem_req = 0, mem_we = 0; mem_addr and mem_wdata hold their last values.
  - mem_req and mem_we are registered.
  - mem_ready sampled in IDLE is ignored.
- Completion:
  - D_ACC with mem_ready: next edge sets dm_ack = 1 and dm_rdata = mem_rdata (read) or 0 (write), then goes to IDLE.
  - I_BEAT0 with mem_ready: latch beat0 and go to I_BEAT1.
  - I_BEAT1 with mem_ready: next edge sets if_ack = 1 and if_data = {mem_rdata[15:0], beat0}, then goes to IDLE.
  - The ack, error and data outputs are cleared the following cycle.
- Latency:
  - Request seen at edge N; mem_req high from cycle N+1.
  - With zero-wait memory, dm_ack is high in cycle N+2 and if_ack in cycle N+3.
  - Minimum access spacing: 3 cycles for data, 4 for fetch.
- Timeout:
  - wait_cnt counts access-state cycles with mem_ready low; it clears on a beat transition and in IDLE.
  - When wait_cnt reaches TIMEOUT, the access is aborted: the corresponding ack and err pulse together, data = 0, state goes to IDLE. Aborting in I_BEAT1 discards beat0.
- Starvation:
  - starve_cnt increments, saturating at MAX_WAIT, on each data grant while if_req = 1.
  - starve_cnt clears on a fetch grant, or in an IDLE cycle with if_req = 0.
- Simultaneous requests:
  - With both requesting and starve_cnt < MAX_WAIT, data wins.
  - A data request arriving during a fetch waits; it is not preempted.
- if_ack and dm_ack are never high in the same cycle.

Test Plan:
- Reset then idle: rst pulse mid-cycle (async) -> every output 0 immediately; mem_req stays 0 with no requests.
- Data read, zero-wait memory: dm_req = 1, dm_addr = 0x40, mem_ready returned with mem_rdata = 0x1122334455667788 -> mem_addr = 0x40, mem_we = 0; dm_ack pulses 2 cycles after the request edge with dm_rdata = 0x1122334455667788. Data write, dm_we = 1, dm_wdata = 0xAB -> mem_we = 1, mem_wdata = 0xAB, dm_rdata = 0.
- Fetch at 0xFFFFFFFFFFFFFFF8, beats 0x0706050403020100 and 0x0F0E0D0C0B0A0908 -> second beat address = 0x0; if_data = 0x09080706050403020100; if_ack 3 cycles after request.
- Contention: if_req and dm_req held, dm_req re-asserted after each dm_ack -> exactly 3 data grants, then a fetch grant; starve_cnt returns to 0.
- Timeout: dm_req with mem_ready held at 0 -> dm_ack and dm_err pulse together after 15 wait cycles, dm_rdata = 0, busy falls.
- Reset during I_BEAT1 -> no if_ack; after release, a held if_req restarts at I_BEAT0 with the original if_addr.
